mcast_scheduler: RTL

Bus-side scheduler for one row of MultiCasters. Arbitrates the ifmap, filter and psum buffer request channels round-robin. Drives the shared bus data, `CASTER_EN` one-hot and `TAG` toward the casters. For psum issues, it collects the accumulated partial sum the casters return and hands it to the output buffer over a valid/ready channel. It sits between the global buffers and the `BUS_IF` of every MultiCaster in the row.

---
 rtl/mcast_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mcast_scheduler.sv
// Bus-side scheduler for one MultiCaster row: round-robin arbitration of ifmap/filter/psum
// requests, one-cycle caster enable, psum result return. Optional watchdog: MCAST_SCHED_TIMEOUT_EN.
module mcast_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_COL        = 4,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [2:0]                req_valid,
    output logic [2:0]                req_ready,
    input  logic [3*TAG_WIDTH-1:0]    req_tag,
    input  logic [DATA_WIDTH-1:0]     ifmap_data,
    input  logic [DATA_WIDTH-1:0]     fltr_data,
    input  logic [2*DATA_WIDTH-1:0]   psum_data,
    output logic [DATA_WIDTH-1:0]     bus_ifmap_data,
    output logic [DATA_WIDTH-1:0]     bus_fltr_data,
    output logic [2*DATA_WIDTH-1:0]   bus_psum_data,
    output logic [2:0]                bus_caster_en,
    output logic [TAG_WIDTH-1:0]      bus_tag,
    input  logic                      bus_caster_ready,
    input  logic                      bus_caster_valid,
    input  logic [2*DATA_WIDTH-1:0]   bus_psum_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_data,
    output logic [TAG_WIDTH-1:0]      res_tag,
    output logic                      busy,
    output logic [15:0]               psum_done_cnt,
    output logic                      err_timeout
);

    if (((2 ** TAG_WIDTH) < NUM_COL) || (TIMEOUT_CYCLES < 1)) begin : g_param_chk
        $error("mcast_scheduler: TAG_WIDTH too small for NUM_COL or TIMEOUT_CYCLES < 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESULT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  win;
    logic [1:0]  win_sel;
    logic        found;
    logic        grant;
    logic        timeout_hit;

    // Round-robin scan starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        found   = 1'b0;
        win_sel = '0;
        for (int unsigned off = 0; off < 3; off++) begin
            int unsigned idx;
            idx = int'(rr_ptr) + off;
            if (idx >= 3) idx = idx - 3;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_sel = 2'(idx);
            end
        end
    end

    assign grant = (state == IDLE) && bus_caster_ready && found;

`ifdef MCAST_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        bus_caster_en = '0;
        res_valid     = 1'b0;
        timeout_hit   = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant) begin
                    req_ready[win_sel] = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                bus_caster_en[win] = 1'b1;
                state_nxt          = (win == 2'd2) ? WAIT_RES : IDLE;
            end
            WAIT_RES: begin
                if (bus_caster_valid) begin
                    state_nxt = RESULT;
                end
`ifdef MCAST_SCHED_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr         <= '0;
            win            <= '0;
            bus_ifmap_data <= '0;
            bus_fltr_data  <= '0;
            bus_psum_data  <= '0;
            bus_tag        <= '0;
            res_data       <= '0;
            res_tag        <= '0;
            psum_done_cnt  <= '0;
        end else begin
            if (grant) begin
                win    <= win_sel;
                rr_ptr <= (win_sel == 2'd2) ? 2'd0 : win_sel + 2'd1;
                case (win_sel)
                    2'd0: begin
                        bus_ifmap_data <= ifmap_data;
                        bus_tag        <= req_tag[0 +: TAG_WIDTH];
                    end
                    2'd1: begin
                        bus_fltr_data <= fltr_data;
                        bus_tag       <= req_tag[TAG_WIDTH +: TAG_WIDTH];
                    end
                    default: begin
                        bus_psum_data <= psum_data;
                        bus_tag       <= req_tag[2*TAG_WIDTH +: TAG_WIDTH];
                    end
                endcase
            end
            if (state == WAIT_RES && bus_caster_valid) begin
                res_data <= bus_psum_result;
                res_tag  <= bus_tag;
            end
            if (state == RESULT && res_ready) begin
                psum_done_cnt <= psum_done_cnt + 16'd1;
            end
        end
    end

`ifdef MCAST_SCHED_TIMEOUT_EN
    // Counter is cleared while in ISSUE so each WAIT_RES visit starts from zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == WAIT_RES) tcnt <= tcnt + TW'(1);
            else                   tcnt <= '0;
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule
